fp_multiplier_pipe: RTL

- Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with a valid/ready handshake and exception flags.
- Successor to the single-precision combinational-output multiplier. Adds a configurable exponent/mantissa width, back-pressure, round-to-nearest-even, and Inf/NaN/overflow handling.
- Sits between the operand-issue logic and the result writeback in the arithmetic datapath.

---
 rtl/fp_multiplier_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fp_multiplier_pipe.sv
// Three-stage pipelined floating-point multiplier, parametrised widths.
// Valid/ready handshake, round-to-nearest-even, Inf/NaN/overflow flags.
module fp_multiplier_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic [2:0]           flags
);

   localparam int EW   = EXP_W + 2;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int SB   = EXP_W + MAN_W;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int EMAX = (1 << EXP_W) - 1;

   typedef enum logic [1:0] {
      C_NORM,
      C_ZERO,
      C_INF,
      C_NAN
   } cls_t;

   logic             w_en;
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic             w_za, w_zb, w_ia, w_ib, w_na, w_nb;
   logic [EW-1:0]    w_e1;
   cls_t             w_c1;
   logic [PW-1:0]    w_prod;
   logic [PW-2:0]    w_low;
   logic             w_g, w_st, w_up;
   logic [MAN_W:0]   w_fr;
   logic [EW-1:0]    w_ef;
   logic             w_ovf, w_unf;
   logic [SB:0]      w_res;
   logic [2:0]       w_flg;

   logic             r_v1, r_v2, r_v3;
   logic             r_s1, r_s2;
   logic [EW-1:0]    r_e1, r_e2;
   logic [MAN_W:0]   r_ma1, r_mb1;
   cls_t             r_c1, r_c2;
   logic [PW-1:0]    r_p2;
   logic [SB:0]      r_res;
   logic [2:0]       r_flg;

   assign w_en      = out_ready || !r_v3;
   assign in_ready  = w_en;
   assign out_valid = r_v3;
   assign result    = r_res;
   assign flags     = r_flg;

   assign w_ea = a[SB-1:MAN_W];
   assign w_eb = b[SB-1:MAN_W];
   assign w_fa = a[MAN_W-1:0];
   assign w_fb = b[MAN_W-1:0];

   // subnormal inputs are treated as zero
   assign w_za = (w_ea == '0);
   assign w_zb = (w_eb == '0);
   assign w_ia = (&w_ea) && (w_fa == '0);
   assign w_ib = (&w_eb) && (w_fb == '0);
   assign w_na = (&w_ea) && (|w_fa);
   assign w_nb = (&w_eb) && (|w_fb);

   assign w_e1 = {2'b00, w_ea} + {2'b00, w_eb} - EW'(BIAS);

   always_comb begin
      w_c1 = C_NORM;
      if (w_na || w_nb || (w_za && w_ib) || (w_ia && w_zb))
         w_c1 = C_NAN;
      else if (w_ia || w_ib)
         w_c1 = C_INF;
      else if (w_za || w_zb)
         w_c1 = C_ZERO;
   end

   assign w_prod = {{(MAN_W+1){1'b0}}, r_ma1}
                 * {{(MAN_W+1){1'b0}}, r_mb1};

   // drop the leading one; the kept bits are fraction, guard, sticky
   assign w_low = r_p2[PW-1] ? r_p2[PW-2:0]
                             : {r_p2[PW-3:0], 1'b0};
   assign w_g   = w_low[MAN_W];
   assign w_st  = |w_low[MAN_W-1:0];
   assign w_up  = w_g && (w_st || w_low[MAN_W+1]);
   assign w_fr  = {1'b0, w_low[PW-2 -: MAN_W]}
                + {{MAN_W{1'b0}}, w_up};

   assign w_ef = r_e2 + EW'(r_p2[PW-1]) + EW'(w_fr[MAN_W]);

   assign w_ovf = !w_ef[EW-1]
               && (w_ef[EW-2:0] >= (EW-1)'(EMAX));
   assign w_unf = w_ef[EW-1] || (w_ef == '0);

   always_comb begin
      w_res = '0;
      w_flg = '0;
      unique case (r_c2)
         C_NAN: begin
            w_res = {1'b0, {EXP_W{1'b1}},
                     1'b1, {(MAN_W-1){1'b0}}};
            w_flg = 3'b100;
         end
         C_INF:  w_res = {r_s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         C_ZERO: w_res = {r_s2, {SB{1'b0}}};
         default: begin
            if (w_ovf) begin
               w_res = {r_s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               w_flg = 3'b010;
            end else if (w_unf) begin
               w_res = {r_s2, {SB{1'b0}}};
               w_flg = 3'b001;
            end else begin
               w_res = {r_s2, w_ef[EXP_W-1:0], w_fr[MAN_W-1:0]};
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_e1  <= '0;
         r_e2  <= '0;
         r_ma1 <= '0;
         r_mb1 <= '0;
         r_c1  <= C_NORM;
         r_c2  <= C_NORM;
         r_p2  <= '0;
         r_res <= '0;
         r_flg <= '0;
      end else if (w_en) begin
         r_v1  <= in_valid;
         r_s1  <= a[SB] ^ b[SB];
         r_e1  <= w_e1;
         r_ma1 <= {1'b1, w_fa};
         r_mb1 <= {1'b1, w_fb};
         r_c1  <= w_c1;
         r_v2  <= r_v1;
         r_s2  <= r_s1;
         r_e2  <= r_e1;
         r_p2  <= w_prod;
         r_c2  <= r_c1;
         r_v3  <= r_v2;
         r_res <= w_res;
         r_flg <= w_flg;
      end
   end

endmodule
